wb_rr_arbiter: RTL and testbench

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

---
 rtl/wb_rr_arbiter_pkg.sv | 36 +++
 rtl/wb_arb_defs.vh | 11 +
 rtl/wb_arb_wdt.sv | 41 ++++
 rtl/wb_rr_arbiter.sv | 146 ++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_rr_arbiter_pkg.sv
// Types and helpers shared by the round-robin Wishbone arbiter and its
// stall watchdog; the raw encodings come from wb_arb_defs.vh.
`include "wb_arb_defs.vh"

package wb_rr_arbiter_pkg;

  localparam int CNT_W = `WB_ARB_CNT_W;

  typedef enum logic [1:0] {
    ST_IDLE = `WB_ARB_IDLE,
    ST_GNT0 = `WB_ARB_GNT0,
    ST_GNT1 = `WB_ARB_GNT1
  } arb_state_e;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
  } wb_req_t;

  // The unused encoding 2'b11 decodes to "no owner" so grant_o stays one-hot.
  function automatic logic [1:0] grant_of(input arb_state_e s);
    logic [1:0] g;
    g = 2'b00;
    case (s)
      ST_GNT0: g = 2'b01;
      ST_GNT1: g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wb_arb_defs.vh
// Shared encodings for the two-master Wishbone arbiter: FSM state codes and
// the width of the stall watchdog counter.
`ifndef WB_ARB_DEFS_VH
`define WB_ARB_DEFS_VH

`define WB_ARB_IDLE  2'b00
`define WB_ARB_GNT0  2'b01
`define WB_ARB_GNT1  2'b10
`define WB_ARB_CNT_W 10

`endif

// File: rtl/wb_arb_wdt.sv
// Stall watchdog: counts consecutive stalled strobe cycles and emits a
// single-cycle timeout pulse when the count reaches TIMEOUT-1.
module wb_arb_wdt
  import wb_rr_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic timeout_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    timeout_o = run & ~clr & (cnt_q == CNT_LAST);
    cnt_d     = cnt_q;
    if (clr || timeout_o) begin
      cnt_d = '0;
    end else if (run && (cnt_q != CNT_MAX)) begin
      // Saturate rather than wrap so a stuck count can never alias to zero.
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter with cycle-granular grants,
// one-cycle grant latency and a per-transfer stall timeout.
//
// Handshake: a master owns the slave from the edge after its cyc is seen until
// it drops cyc; a beat completes on any cycle where the granted stb and
// s_ack_i are both high, and a stalled beat ends with a one-cycle err instead.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int unsigned timeout_cycles = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);

  arb_state_e state_q;
  arb_state_e state_d;
  logic       last_owner_q;
  logic       last_owner_d;
  logic [1:0] grant;
  wb_req_t    m0_req;
  wb_req_t    m1_req;
  wb_req_t    sel_req;
  logic       wdt_run;
  logic       wdt_clr;
  logic       timeout;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        // last_owner_q == 1 means m1 went last, so m0 wins a tie.
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_owner_q ? ST_GNT0 : ST_GNT1;
        end else if (m0_cyc_i) begin
          state_d = ST_GNT0;
        end else if (m1_cyc_i) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!m0_cyc_i) begin
          state_d = m1_cyc_i ? ST_GNT1 : ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (!m1_cyc_i) begin
          state_d = m0_cyc_i ? ST_GNT0 : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_GNT0 && state_q != ST_GNT0) begin
      last_owner_d = 1'b0;
    end else if (state_d == ST_GNT1 && state_q != ST_GNT1) begin
      last_owner_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign grant   = grant_of(state_q);
  assign grant_o = grant;

  assign m0_req = '{adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i,
                    we: m0_we_i, cyc: m0_cyc_i, stb: m0_stb_i};
  assign m1_req = '{adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i,
                    we: m1_we_i, cyc: m1_cyc_i, stb: m1_stb_i};

  always_comb begin
    sel_req = '0;
    case (state_q)
      ST_GNT0: sel_req = m0_req;
      ST_GNT1: sel_req = m1_req;
      default: sel_req = '0;
    endcase
  end

  // A stalled cycle is a granted strobe without ack; anything else, or a
  // change of owner, restarts the count.
  assign wdt_run = sel_req.stb & ~s_ack_i;
  assign wdt_clr = ~wdt_run | (state_d != state_q);

  wb_arb_wdt #(
    .TIMEOUT (timeout_cycles)
  ) u_wdt (
    .clk       (clk),
    .rst       (rst),
    .run       (wdt_run),
    .clr       (wdt_clr),
    .timeout_o (timeout)
  );

  assign s_adr_o = sel_req.adr;
  assign s_dat_o = sel_req.dat;
  assign s_sel_o = sel_req.sel;
  assign s_we_o  = sel_req.we;
  assign s_cyc_o = sel_req.cyc;
  // The timed-out beat is withdrawn from the slave on the cycle err is raised.
  assign s_stb_o = sel_req.stb & ~timeout;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign m0_ack_o = s_ack_i & grant[0] & m0_stb_i;
  assign m1_ack_o = s_ack_i & grant[1] & m1_stb_i;
  assign m0_err_o = timeout & grant[0];
  assign m1_err_o = timeout & grant[1];

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: single transfer, contention and handover,
// burst holding, stall timeout, ack/timeout collision and async reset.
module tb_wb_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic [3:0]  m0_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m1_sel_i;
  logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
  logic [1:0]  grant_o;

  int n_checks;
  int n_errors;
  logic [31:0] exp_q[$];

  wb_rr_arbiter #(
    .timeout_cycles (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_adr_i (m0_adr_i),
    .m0_dat_i (m0_dat_i),
    .m0_dat_o (m0_dat_o),
    .m0_sel_i (m0_sel_i),
    .m0_we_i  (m0_we_i),
    .m0_cyc_i (m0_cyc_i),
    .m0_stb_i (m0_stb_i),
    .m0_ack_o (m0_ack_o),
    .m0_err_o (m0_err_o),
    .m1_adr_i (m1_adr_i),
    .m1_dat_i (m1_dat_i),
    .m1_dat_o (m1_dat_o),
    .m1_sel_i (m1_sel_i),
    .m1_we_i  (m1_we_i),
    .m1_cyc_i (m1_cyc_i),
    .m1_stb_i (m1_stb_i),
    .m1_ack_o (m1_ack_o),
    .m1_err_o (m1_err_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_we_o   (s_we_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .grant_o  (grant_o)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
    $fatal(1, "time limit");
  end

  // Driver tasks.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 1'b0;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 1'b0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    s_dat_i  = '0; s_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    rst = 1'b1;
    // Requests and ack presented during reset must be ignored.
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_00ff; s_ack_i = 1'b1;
    repeat (3) tick();
    #1;
    check("rst_grant", 32'(grant_o), 32'h0);
    check("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    check("rst_s_stb", 32'(s_stb_o), 32'h0);
    check("rst_s_adr", s_adr_o, 32'h0);
    check("rst_m0_ack", 32'(m0_ack_o), 32'h0);
    check("rst_m0_err", 32'(m0_err_o), 32'h0);
    clear_inputs();
    tick();
    rst = 1'b0;

    // Single m0 read, slave acks on the second granted cycle.
    m0_adr_i = 32'h2000_0004; m0_sel_i = 4'hf; m0_we_i = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    #1;
    check("t1_pre_grant", 32'(grant_o), 32'h0);
    check("t1_pre_cyc", 32'(s_cyc_o), 32'h0);
    tick(); #1;
    check("t1_grant", 32'(grant_o), 32'h1);
    check("t1_s_cyc", 32'(s_cyc_o), 32'h1);
    check("t1_s_stb", 32'(s_stb_o), 32'h1);
    check("t1_s_adr", s_adr_o, 32'h2000_0004);
    check("t1_s_sel", 32'(s_sel_o), 32'hf);
    check("t1_s_we", 32'(s_we_o), 32'h0);
    check("t1_ack_wait", 32'(m0_ack_o), 32'h0);
    tick();
    s_dat_i = 32'hcafe_f00d; s_ack_i = 1'b1;
    exp_q.push_back(32'hcafe_f00d);
    #1;
    check("t1_m0_ack", 32'(m0_ack_o), 32'h1);
    check("t1_m1_ack", 32'(m1_ack_o), 32'h0);
    check("t1_m0_dat", m0_dat_o, exp_q.pop_front());
    tick();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    #1;
    check("t1_ack_once", 32'(m0_ack_o), 32'h0);
    check("t1_s_cyc_drop", 32'(s_cyc_o), 32'h0);
    tick(); #1;
    check("t1_idle", 32'(grant_o), 32'h0);

    // Ack delivered on the same cycle the master drops cyc.
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    tick();
    m0_cyc_i = 1'b0; s_ack_i = 1'b1;
    #1;
    check("t1b_ack_on_drop", 32'(m0_ack_o), 32'h1);
    tick();
    m0_stb_i = 1'b0; s_ack_i = 1'b0;
    #1;
    check("t1b_no_ack", 32'(m0_ack_o), 32'h0);
    tick(); #1;
    check("t1b_idle", 32'(grant_o), 32'h0);

    // Contention right after reset: m0 first, gapless handover, m0 again.
    do_reset();
    m0_adr_i = 32'h1000_0000; m1_adr_i = 32'h4000_0008;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick(); #1;
    check("t2_first_m0", 32'(grant_o), 32'h1);
    check("t2_adr_m0", s_adr_o, 32'h1000_0000);
    s_ack_i = 1'b1;
    #1;
    check("t2_m0_ack", 32'(m0_ack_o), 32'h1);
    check("t2_m1_no_ack", 32'(m1_ack_o), 32'h0);
    tick();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    #1;
    check("t2_hold_drop", 32'(grant_o), 32'h1);
    tick(); #1;
    check("t2_handover", 32'(grant_o), 32'h2);
    check("t2_adr_m1", s_adr_o, 32'h4000_0008);
    check("t2_cyc_m1", 32'(s_cyc_o), 32'h1);
    s_ack_i = 1'b1;
    #1;
    check("t2_m1_ack", 32'(m1_ack_o), 32'h1);
    check("t2_m0_no_ack", 32'(m0_ack_o), 32'h0);
    tick();
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick(); #1;
    check("t2_idle", 32'(grant_o), 32'h0);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick(); #1;
    check("t2_rr_m0", 32'(grant_o), 32'h1);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick(); #1;
    check("t2_idle2", 32'(grant_o), 32'h0);

    // m1 4-beat burst with m0 waiting.
    m1_adr_i = 32'h3000_0000; m1_dat_i = 32'hdead_beef; m1_sel_i = 4'h3;
    m1_we_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h1000_0010;
    #1;
    check("t3_grant", 32'(grant_o), 32'h2);
    check("t3_s_we", 32'(s_we_o), 32'h1);
    check("t3_s_dat", s_dat_o, 32'hdead_beef);
    check("t3_s_sel", 32'(s_sel_o), 32'h3);
    for (int beat = 0; beat < 4; beat++) begin
      m1_stb_i = 1'b1; s_ack_i = 1'b1;
      #1;
      check("t3_beat_ack", 32'(m1_ack_o), 32'h1);
      check("t3_beat_m0", 32'(m0_ack_o), 32'h0);
      check("t3_beat_grant", 32'(grant_o), 32'h2);
      tick();
      m1_stb_i = 1'b0; s_ack_i = 1'b0;
      #1;
      check("t3_gap_grant", 32'(grant_o), 32'h2);
      check("t3_gap_stb", 32'(s_stb_o), 32'h0);
      check("t3_gap_cyc", 32'(s_cyc_o), 32'h1);
      tick();
    end
    m1_cyc_i = 1'b0;
    #1;
    check("t3_end_grant", 32'(grant_o), 32'h2);
    tick(); #1;
    check("t3_to_m0", 32'(grant_o), 32'h1);
    check("t3_m0_adr", s_adr_o, 32'h1000_0010);
    s_ack_i = 1'b1;
    #1;
    check("t3_m0_ack", 32'(m0_ack_o), 32'h1);
    tick();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_we_i = 1'b0;
    tick(); #1;
    check("t3_idle", 32'(grant_o), 32'h0);

    // Stall timeout with timeout_cycles = 8, then ack colliding with timeout.
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      #1;
      check("t4_err", 32'(m0_err_o), 32'(k == 8));
      check("t4_stb", 32'(s_stb_o), 32'(k != 8));
      check("t4_no_ack", 32'(m0_ack_o), 32'h0);
      check("t4_m1_err", 32'(m1_err_o), 32'h0);
      tick();
    end
    for (int k = 9; k <= 15; k++) begin
      #1;
      check("t5_pre_err", 32'(m0_err_o), 32'h0);
      tick();
    end
    s_ack_i = 1'b1;
    #1;
    check("t5_coll_ack", 32'(m0_ack_o), 32'h1);
    check("t5_coll_err", 32'(m0_err_o), 32'h0);
    check("t5_coll_stb", 32'(s_stb_o), 32'h1);
    tick();
    s_ack_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      check("t5_restart_err", 32'(m0_err_o), 32'(k == 8));
      tick();
    end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick(); #1;
    check("t5_idle", 32'(grant_o), 32'h0);

    // Asynchronous reset in the middle of an m1 burst.
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick(); #1;
    check("t6_grant", 32'(grant_o), 32'h2);
    s_ack_i = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check("t6_rst_grant", 32'(grant_o), 32'h0);
    check("t6_rst_cyc", 32'(s_cyc_o), 32'h0);
    check("t6_rst_stb", 32'(s_stb_o), 32'h0);
    check("t6_rst_ack", 32'(m1_ack_o), 32'h0);
    check("t6_rst_err", 32'(m1_err_o), 32'h0);
    tick(); #1;
    check("t6_rst_hold", 32'(grant_o), 32'h0);
    clear_inputs();
    rst = 1'b0;
    tick();

    // Final report.
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
